// File: rtl/mem_align_pkg.sv
// Shared types and helpers for the load/store aligner.
//   size_e        : access size encoding (byte/half/word/dword)
//   align_entry_t : per-load tracking entry {off,size,sext}; the offset field
//                   is sized for the widest supported data path (8 lanes)
//   size_bytes    : number of bytes covered by an access size
//   is_misaligned : offset/size legality check
package mem_align_pkg;

    localparam int MAX_OFF_W = 3;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef struct packed {
        logic [MAX_OFF_W-1:0] off;
        size_e                size;
        logic                 sext;
    } align_entry_t;

    localparam int ENTRY_W = $bits(align_entry_t);

    function automatic logic [3:0] size_bytes(input size_e size);
        logic [3:0] n;
        case (size)
            SZ_BYTE:  n = 4'd1;
            SZ_HALF:  n = 4'd2;
            SZ_WORD:  n = 4'd4;
            SZ_DWORD: n = 4'd8;
            default:  n = 4'd8;
        endcase
        return n;
    endfunction

    // dword_ok is low on a 32-bit data path, where any dword access is illegal.
    function automatic logic is_misaligned(input logic [MAX_OFF_W-1:0] off,
                                           input size_e               size,
                                           input logic                dword_ok);
        logic bad;
        case (size)
            SZ_BYTE:  bad = 1'b0;
            SZ_HALF:  bad = off[0];
            SZ_WORD:  bad = |off[1:0];
            SZ_DWORD: bad = ~dword_ok | (|off[2:0]);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/align_fifo.sv
// Show-ahead FIFO holding alignment entries of outstanding loads.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write an entry (caller never pushes while full)
//   i_pop          : drop the head entry (caller never pops while empty)
//   o_data         : head entry, valid whenever o_empty is low
//   o_full/o_empty : occupancy flags from the wrap-bit pointer compare
module align_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [W-1:0]     r_mem [DEPTH];

    // Pointer update: the extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/mem_align.sv
// Load/store aligner between the memory stage and the data cache port.
//   clk, rst          : clock, asynchronous active-low reset
//   req_*             : sized, byte-addressed request (valid/ready)
//   mem_*             : cache request with lane mask and lane-shifted data
//   rsp_valid/rsp_data: in-order raw read responses
//   out_valid/out_data: aligned, zero/sign-extended load result (registered)
//   err_misalign      : pulse, a misaligned request was consumed and dropped
//   err_orphan        : pulse, a response arrived with no load outstanding
//   busy              : at least one load outstanding
module mem_align
    import mem_align_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [$clog2(DATA_W/8)-1:0]   req_off,
    input  logic [1:0]                    req_size,
    input  logic                          req_sext,
    input  logic [DATA_W-1:0]             req_data,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic                          mem_we,
    output logic [DATA_W/8-1:0]           mem_mask,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          rsp_valid,
    input  logic [DATA_W-1:0]             rsp_data,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          err_misalign,
    output logic                          err_orphan,
    output logic                          busy
);

    localparam int   LANES    = DATA_W / 8;
    localparam int   OFF_W    = $clog2(LANES);
    localparam logic DWORD_OK = (DATA_W == 64) ? 1'b1 : 1'b0;

    function automatic logic [DATA_W-1:0] lanes_to_bits(input logic [LANES-1:0] lanes);
        logic [DATA_W-1:0] bits;
        bits = '0;
        for (int i = 0; i < LANES; i++) begin
            bits[8*i +: 8] = {8{lanes[i]}};
        end
        return bits;
    endfunction

    size_e                w_size;
    logic [MAX_OFF_W-1:0] w_off_ext;
    logic [3:0]           w_req_bytes;
    logic [LANES-1:0]     w_req_lanes;
    logic [DATA_W-1:0]    w_store_shift;
    logic                 w_misalign;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    align_entry_t         w_push_entry;
    align_entry_t         w_head;
    logic [ENTRY_W-1:0]   w_push_bits;
    logic [ENTRY_W-1:0]   w_head_bits;
    logic [3:0]           w_rsp_bytes;
    logic [LANES-1:0]     w_rsp_lanes;
    logic [DATA_W-1:0]    w_rsp_field;
    logic [DATA_W-1:0]    w_rsp_keep;
    logic                 w_sign;
    logic [DATA_W-1:0]    w_load_result;

    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_err_misalign;
    logic                 r_err_orphan;

    // Request decode: legality, lane mask and lane-shifted store data.
    always_comb begin
        w_size    = size_e'(req_size);
        w_off_ext = '0;
        w_off_ext[OFF_W-1:0] = req_off;
        w_misalign  = is_misaligned(w_off_ext, w_size, DWORD_OK);
        w_req_bytes = size_bytes(w_size);
        w_req_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            w_req_lanes[i] = (4'(i) < w_req_bytes);
        end
        w_store_shift = (req_data & lanes_to_bits(w_req_lanes)) << {req_off, 3'b000};
    end

    // Cache handshake: loads also need a free tracking slot; a pop in the same
    // cycle deliberately does not open one.
    always_comb begin
        mem_valid = req_valid & ~w_misalign & (req_we | ~w_full);
        req_ready = w_misalign | (mem_ready & (req_we | ~w_full));
        mem_we    = req_valid & req_we & ~w_misalign;
        if (w_misalign) begin
            mem_mask  = '0;
            mem_wdata = '0;
        end else if (req_we) begin
            mem_mask  = w_req_lanes << req_off;
            mem_wdata = w_store_shift;
        end else begin
            mem_mask  = w_req_lanes << req_off;
            mem_wdata = '0;
        end
    end

    // Tracking FIFO control and entry packing.
    always_comb begin
        w_push = req_valid & ~req_we & ~w_misalign & mem_ready & ~w_full;
        w_pop  = rsp_valid & ~w_empty;
        w_push_entry.off  = w_off_ext;
        w_push_entry.size = w_size;
        w_push_entry.sext = req_sext;
        w_push_bits = w_push_entry;
        w_head      = align_entry_t'(w_head_bits);
    end

    align_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (w_push_bits),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Response extraction: shift the addressed lanes down, keep the access
    // width, then fill the upper bits with zero or the field's sign bit.
    always_comb begin
        w_rsp_field = rsp_data >> {w_head.off, 3'b000};
        w_rsp_bytes = size_bytes(w_head.size);
        w_rsp_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            w_rsp_lanes[i] = (4'(i) < w_rsp_bytes);
        end
        w_rsp_keep = lanes_to_bits(w_rsp_lanes);
        case (w_head.size)
            SZ_BYTE:  w_sign = w_rsp_field[7];
            SZ_HALF:  w_sign = w_rsp_field[15];
            SZ_WORD:  w_sign = w_rsp_field[31];
            default:  w_sign = w_rsp_field[DATA_W-1];
        endcase
        if (w_head.sext & w_sign) begin
            w_load_result = (w_rsp_field & w_rsp_keep) | ~w_rsp_keep;
        end else begin
            w_load_result = w_rsp_field & w_rsp_keep;
        end
    end

    // Registered result and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_err_misalign <= 1'b0;
            r_err_orphan   <= 1'b0;
        end else begin
            r_out_valid    <= w_pop;
            r_err_misalign <= req_valid & w_misalign;
            r_err_orphan   <= rsp_valid & w_empty;
            if (w_pop) begin
                r_out_data <= w_load_result;
            end else begin
                r_out_data <= r_out_data;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign err_misalign = r_err_misalign;
    assign err_orphan   = r_err_orphan;
    assign busy         = ~w_empty;

endmodule

// File: tb/tb_mem_align.sv
module tb_mem_align;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;          // 0: 32-bit instance active, 1: 64-bit instance
    logic        chk_en;
    logic        req_valid, req_we, req_sext, mem_ready, rsp_valid;
    logic [2:0]  req_off;
    logic [1:0]  req_size;
    logic [63:0] req_data, rsp_data;

    logic        a_req_ready, a_mem_valid, a_mem_we, a_out_valid, a_err_mis, a_err_orph, a_busy;
    logic [3:0]  a_mem_mask;
    logic [31:0] a_mem_wdata, a_out_data;
    logic        b_req_ready, b_mem_valid, b_mem_we, b_out_valid, b_err_mis, b_err_orph, b_busy;
    logic [7:0]  b_mem_mask;
    logic [63:0] b_mem_wdata, b_out_data;

    logic        d_req_ready, d_mem_valid, d_mem_we, d_out_valid, d_err_mis, d_err_orph, d_busy;
    logic [7:0]  d_mem_mask;
    logic [63:0] d_mem_wdata, d_out_data;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int off;
        int size;
        bit sext;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    bit          exp_out_valid, exp_err_mis, exp_err_orph;
    logic [63:0] exp_out_data;
    int          c_dw;
    bit          c_mis, c_full, c_mv;

    always #5 clk = ~clk;

    mem_align #(.DATA_W(32), .DEPTH(DEPTH)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_we(req_we),
        .req_off(req_off[1:0]), .req_size(req_size), .req_sext(req_sext),
        .req_data(req_data[31:0]),
        .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_we(a_mem_we),
        .mem_mask(a_mem_mask), .mem_wdata(a_mem_wdata),
        .rsp_valid(rsp_valid & ~sel), .rsp_data(rsp_data[31:0]),
        .out_valid(a_out_valid), .out_data(a_out_data),
        .err_misalign(a_err_mis), .err_orphan(a_err_orph), .busy(a_busy)
    );

    mem_align #(.DATA_W(64), .DEPTH(DEPTH)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_we(req_we),
        .req_off(req_off), .req_size(req_size), .req_sext(req_sext),
        .req_data(req_data),
        .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_we(b_mem_we),
        .mem_mask(b_mem_mask), .mem_wdata(b_mem_wdata),
        .rsp_valid(rsp_valid & sel), .rsp_data(rsp_data),
        .out_valid(b_out_valid), .out_data(b_out_data),
        .err_misalign(b_err_mis), .err_orphan(b_err_orph), .busy(b_busy)
    );

    assign d_req_ready = sel ? b_req_ready : a_req_ready;
    assign d_mem_valid = sel ? b_mem_valid : a_mem_valid;
    assign d_mem_we    = sel ? b_mem_we    : a_mem_we;
    assign d_out_valid = sel ? b_out_valid : a_out_valid;
    assign d_err_mis   = sel ? b_err_mis   : a_err_mis;
    assign d_err_orph  = sel ? b_err_orph  : a_err_orph;
    assign d_busy      = sel ? b_busy      : a_busy;
    assign d_mem_mask  = sel ? b_mem_mask  : {4'b0000, a_mem_mask};
    assign d_mem_wdata = sel ? b_mem_wdata : {32'h0, a_mem_wdata};
    assign d_out_data  = sel ? b_out_data  : {32'h0, a_out_data};

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [63:0] dwmask(input int dw);
        return (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic bit mis_f(input int dw, input int off, input int size);
        return (size == 3 && dw == 32) || ((off % (1 << size)) != 0);
    endfunction

    function automatic logic [7:0] mask_f(input int off, input int size);
        logic [15:0] m;
        m = ((16'd1 << (1 << size)) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] wdata_f(input int dw, input int off, input int size, input logic [63:0] data);
        logic [127:0] fm, r;
        fm = (128'd1 << (8 * (1 << size))) - 128'd1;
        r  = ({64'h0, data} & fm) << (8 * off);
        return r[63:0] & dwmask(dw);
    endfunction

    function automatic logic [63:0] ext_f(input int dw, input int off, input int size, input bit sext, input logic [63:0] rsp);
        logic [63:0] f, keep;
        int          nb;
        nb   = 1 << size;
        f    = (rsp & dwmask(dw)) >> (8 * off);
        keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        f    = f & keep;
        if (sext && f[8*nb-1]) f = f | ~keep;
        return f & dwmask(dw);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (chk_en && rst === 1'b1) begin
            c_dw   = sel ? 64 : 32;
            c_mis  = mis_f(c_dw, int'(req_off), int'(req_size));
            c_full = (q.size() == DEPTH);
            chk("out_valid", 64'(d_out_valid), 64'(exp_out_valid));
            if (exp_out_valid) chk("out_data", d_out_data, exp_out_data);
            chk("err_misalign", 64'(d_err_mis), 64'(exp_err_mis));
            chk("err_orphan", 64'(d_err_orph), 64'(exp_err_orph));
            chk("busy", 64'(d_busy), 64'(q.size() != 0));
            c_mv = req_valid && !c_mis && (req_we || !c_full);
            chk("mem_valid", 64'(d_mem_valid), 64'(c_mv));
            if (req_valid)
                chk("req_ready", 64'(d_req_ready), 64'(c_mis || (mem_ready && (req_we || !c_full))));
            if (c_mv) begin
                chk("mem_mask", 64'(d_mem_mask), 64'(mask_f(int'(req_off), int'(req_size))));
                chk("mem_we", 64'(d_mem_we), 64'(req_we));
                chk("mem_wdata", d_mem_wdata,
                    req_we ? wdata_f(c_dw, int'(req_off), int'(req_size), req_data) : 64'h0);
            end
            exp_err_mis   = req_valid && c_mis;
            exp_err_orph  = rsp_valid && (q.size() == 0);
            exp_out_valid = rsp_valid && (q.size() != 0);
            if (exp_out_valid) begin
                e = q.pop_front();
                exp_out_data = ext_f(c_dw, e.off, e.size, e.sext, rsp_data);
            end
            if (c_mv && !req_we && mem_ready)
                q.push_back('{off: int'(req_off), size: int'(req_size), sext: req_sext});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_we = 1'b0; req_off = 3'd0; req_size = 2'd0;
        req_sext = 1'b0; req_data = 64'h0; mem_ready = 1'b1;
        rsp_valid = 1'b0; rsp_data = 64'h0;
    endtask

    task automatic drv(input bit we, input int off, input int size, input bit sext, input logic [63:0] data);
        req_valid = 1'b1; req_we = we; req_off = 3'(off); req_size = 2'(size);
        req_sext = sext; req_data = data; mem_ready = 1'b1;
    endtask

    task automatic do_reset(input bit new_sel);
        rst = 1'b0;
        sel = new_sel;
        q.delete();
        exp_out_valid = 1'b0; exp_err_mis = 1'b0; exp_err_orph = 1'b0; exp_out_data = 64'h0;
        #1;
        chk("rst_busy", 64'(d_busy), 64'd0);
        chk("rst_out_valid", 64'(d_out_valid), 64'd0);
        chk("rst_out_data", d_out_data, 64'd0);
        chk("rst_errs", 64'({d_err_mis, d_err_orph}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic rand_cycle(input int lanes);
        int off;
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = ($urandom_range(0, 2) == 0);
        req_size  = 2'($urandom_range(0, 3));
        if (lanes == 4 && req_size == 2'd3 && $urandom_range(0, 1) == 0) req_size = 2'd2;
        off = $urandom_range(0, lanes - 1);
        if ($urandom_range(0, 3) != 0) off = off & ~((1 << req_size) - 1);
        req_off   = 3'(off);
        req_sext  = 1'($urandom_range(0, 1));
        req_data  = {$urandom(), $urandom()};
        mem_ready = ($urandom_range(0, 3) != 0);
        rsp_valid = (q.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
        rsp_data  = {$urandom(), $urandom()};
    endtask

    initial begin
        chk_en = 1'b0;
        rst = 1'b0;
        sel = 1'b0;
        idle();
        step();
        do_reset(1'b0);
        chk_en = 1'b1;

        // 32-bit: byte store at offset 2
        drv(1'b1, 2, 0, 1'b0, 64'h0000_00AB);
        #2;
        chk("st_byte_valid", 64'(d_mem_valid), 64'd1);
        chk("st_byte_mask", 64'(d_mem_mask), 64'h04);
        chk("st_byte_wdata", d_mem_wdata, 64'h00AB_0000);
        step();

        // half load, sign-extended then zero-extended
        drv(1'b0, 2, 1, 1'b1, 64'h0);
        step();
        req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 64'h8001_1234;
        step();
        rsp_valid = 1'b0;
        #2;
        chk("ld_half_sext_valid", 64'(d_out_valid), 64'd1);
        chk("ld_half_sext", d_out_data, 64'hFFFF_8001);
        step();
        drv(1'b0, 2, 1, 1'b0, 64'h0);
        step();
        req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 64'h8001_1234;
        step();
        rsp_valid = 1'b0;
        #2;
        chk("ld_half_zext", d_out_data, 64'h0000_8001);

        // misaligned word load
        step();
        drv(1'b0, 1, 2, 1'b0, 64'h0);
        #2;
        chk("mis_mem_valid", 64'(d_mem_valid), 64'd0);
        chk("mis_req_ready", 64'(d_req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        #2;
        chk("mis_err", 64'(d_err_mis), 64'd1);
        chk("mis_busy", 64'(d_busy), 64'd0);

        // dword on 32-bit path is illegal
        step();
        drv(1'b0, 0, 3, 1'b0, 64'h0);
        #2;
        chk("dword32_mem_valid", 64'(d_mem_valid), 64'd0);
        step();
        req_valid = 1'b0;

        // orphan response
        rsp_valid = 1'b1; rsp_data = 64'h1234_5678;
        step();
        rsp_valid = 1'b0;
        #2;
        chk("orphan_err", 64'(d_err_orph), 64'd1);
        chk("orphan_no_out", 64'(d_out_valid), 64'd0);

        // fill, stall on full, free a slot, then drain across the wrap
        step();
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 0, 2, 1'b0, 64'h0);
            step();
        end
        drv(1'b0, 0, 2, 1'b0, 64'h0);
        rsp_valid = 1'b1; rsp_data = 64'h1111_1111;
        #2;
        chk("full_stall_ready", 64'(d_req_ready), 64'd0);
        chk("full_stall_valid", 64'(d_mem_valid), 64'd0);
        step();
        rsp_valid = 1'b0;
        #2;
        chk("slot_freed_ready", 64'(d_req_ready), 64'd1);
        chk("first_result", d_out_data, 64'h1111_1111);
        step();
        req_valid = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            rsp_valid = 1'b1;
            rsp_data = {32'h0, {8{4'(i)}}};
            step();
        end
        rsp_valid = 1'b0;
        #2;
        chk("drain_last", d_out_data, 64'h5555_5555);
        chk("drain_busy", 64'(d_busy), 64'd0);

        // reset with two loads outstanding
        step();
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, 0, 2, 1'b0, 64'h0);
            step();
        end
        req_valid = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 2; i++) begin
            rsp_valid = 1'b1; rsp_data = 64'hCAFE_F00D;
            step();
            #2;
            chk("post_rst_orphan", 64'(d_err_orph), 64'd1);
            chk("post_rst_no_out", 64'(d_out_valid), 64'd0);
        end
        rsp_valid = 1'b0;

        // randomized traffic, 32-bit
        for (int i = 0; i < 1500; i++) begin
            step();
            rand_cycle(4);
        end
        step();
        idle();

        // 64-bit instance
        do_reset(1'b1);
        drv(1'b0, 0, 3, 1'b0, 64'h0);
        #2;
        chk("dword_mask", 64'(d_mem_mask), 64'hFF);
        step();
        req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 64'h0123_4567_89AB_CDEF;
        step();
        rsp_valid = 1'b0;
        #2;
        chk("dword_load", d_out_data, 64'h0123_4567_89AB_CDEF);
        step();
        drv(1'b0, 7, 0, 1'b1, 64'h0);
        step();
        req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 64'h8000_0000_0000_0000;
        step();
        rsp_valid = 1'b0;
        #2;
        chk("byte7_sext", d_out_data, 64'hFFFF_FFFF_FFFF_FF80);

        for (int i = 0; i < 1500; i++) begin
            step();
            rand_cycle(8);
        end
        step();
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
